led_seq_engine: RTL and testbench

Parametrised LED pattern sequencer: a writable DEPTH×WIDTH pattern table stepped by an internal prescaler, with loop, one-shot, ping-pong and hold modes. It generalises the fixed 10-LED, 18-entry pattern table used by the LED board to any LED count, table depth and step rate. It sits between the board's control/switch logic and the LED output pins. It drives `led` directly once per step.

---
 rtl/led_seq_engine.sv | 169 ++++++++++++++++
 tb/tb_led_seq_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_engine.sv
// LED pattern sequencer: writable DEPTH x WIDTH table stepped by a prescaler.
// Optional ping-pong mode under `LED_SEQ_PINGPONG_EN (mode 10 falls back to loop otherwise).
module led_seq_engine #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 18,
  parameter int unsigned AW    = 5,
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  input  logic [AW-1:0]    last,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] led,
  output logic [AW-1:0]    step,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [AW-1:0]    last_c;
  logic [AW-1:0]    loop_next;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             tick;
`ifdef LED_SEQ_PINGPONG_EN
  logic             dir_q, dir_d;  // 0 = counting up
`endif

  assign led  = led_q;
  assign step = step_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // Pattern table; out-of-range write addresses match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_addr == AW'(i)) mem_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (step_q == AW'(i)) rd_data = mem_q[i];
    end
  end

  always_comb begin
    last_c    = (last > LAST_MAX) ? LAST_MAX : last;
    loop_next = (step_q >= last_c) ? '0 : step_q + 1'b1;
    tick      = (cnt_q >= period);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
`ifdef LED_SEQ_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      step_d  = '0;
      cnt_d   = '0;
`ifdef LED_SEQ_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else if (start) begin
      state_d = S_RUN;
      step_d  = '0;
      cnt_d   = '0;
`ifdef LED_SEQ_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else if (state_q == S_RUN && !pause) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        unique case (mode)
          2'b00: step_d = loop_next;
          2'b01: begin
            if (step_q >= last_c) begin
              state_d = S_DONE;
              step_d  = last_c;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
`ifdef LED_SEQ_PINGPONG_EN
          // Direction flips on the endpoint itself so each endpoint is shown once.
          2'b10: begin
            if (!dir_q) begin
              if (step_q >= last_c) begin
                if (last_c != '0) begin
                  step_d = last_c - 1'b1;
                  dir_d  = 1'b1;
                end else begin
                  step_d = '0;
                end
              end else begin
                step_d = step_q + 1'b1;
              end
            end else begin
              if (step_q == '0) begin
                if (last_c != '0) begin
                  step_d = AW'(1);
                  dir_d  = 1'b0;
                end
              end else begin
                step_d = step_q - 1'b1;
              end
            end
          end
`else
          2'b10: step_d = loop_next;
`endif
          2'b11: step_d = step_q;
        endcase
      end
    end
  end

  // A stop blanks the LEDs on the same edge it takes effect.
  always_comb begin
    led_d = (stop || state_q == S_IDLE) ? '0 : rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
`ifdef LED_SEQ_PINGPONG_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
`ifdef LED_SEQ_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_seq_engine.sv
// Self-checking bench for led_seq_engine: directed scenarios plus randomized runs
// compared cycle by cycle against a behavioural model.
module tb_led_seq_engine;

  localparam int WIDTH = 10;
  localparam int DEPTH = 18;
  localparam int AW    = 5;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic [1:0]       mode = '0;
  logic [DIV_W-1:0] period = '0;
  logic [AW-1:0]    last = '0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] led;
  logic [AW-1:0]    step;
  logic             busy;
  logic             done;

  led_seq_engine #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW),
    .DIV_W(DIV_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .mode   (mode),
    .period (period),
    .last   (last),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .led    (led),
    .step   (step),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Behavioural model: the sequence position is tracked as plain integers.
  int unsigned m_tab [DEPTH];
  bit          m_run, m_done;
  int          m_pos, m_cnt, m_k;
  int unsigned m_led;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
    m_run = 0; m_done = 0; m_pos = 0; m_cnt = 0; m_k = 0; m_led = 0;
  endtask

  function automatic int eff_last();
    return (int'(last) > DEPTH - 1) ? DEPTH - 1 : int'(last);
  endfunction

  task automatic model_edge();
    int L;
    int unsigned nled;
    if (rst) begin
      model_reset();
      return;
    end
    L = eff_last();
    nled = (stop || !(m_run || m_done)) ? 0 : m_tab[m_pos];
    if (stop) begin
      m_run = 0; m_done = 0; m_pos = 0; m_cnt = 0; m_k = 0;
    end else if (start) begin
      m_run = 1; m_done = 0; m_pos = 0; m_cnt = 0; m_k = 0;
    end else if (m_run && !pause) begin
      if (m_cnt >= int'(period)) begin
        m_cnt = 0;
        case (mode)
          2'd0: m_pos = (m_pos >= L) ? 0 : m_pos + 1;
          2'd1: begin
            if (m_pos >= L) begin
              m_run = 0; m_done = 1; m_pos = L;
            end else m_pos = m_pos + 1;
          end
          2'd2: begin
`ifdef LED_SEQ_PINGPONG_EN
            // Ping-pong is a period-2L walk folded back at L.
            m_k   = (L == 0) ? 0 : (m_k + 1) % (2 * L);
            m_pos = (m_k <= L) ? m_k : 2 * L - m_k;
`else
            m_pos = (m_pos >= L) ? 0 : m_pos + 1;
`endif
          end
          default: ;
        endcase
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (wr_en && int'(wr_addr) < DEPTH) m_tab[int'(wr_addr)] = int'(wr_data);
    m_led = nled;
  endtask

  task automatic compare_all();
    check("led",  32'(led),  m_led);
    check("step", 32'(step), 32'(m_pos));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_led",  32'(led),  0);
    check("rst_step", 32'(step), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic write_entry(input int addr, input int unsigned data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = WIDTH'(data);
    cycle();
  endtask

  int unsigned exp_tp1 [14] = '{'h000, 'h001, 'h001, 'h001, 'h003, 'h003, 'h003,
                                'h007, 'h007, 'h007, 'h00F, 'h00F, 'h00F, 'h001};
`ifdef LED_SEQ_PINGPONG_EN
  int unsigned exp_pp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
  int unsigned exp_pp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

  initial begin
    model_reset();
    apply_reset();

    // Loop mode, 3-cycle dwell
    write_entry(0, 'h001);
    write_entry(1, 'h003);
    write_entry(2, 'h007);
    write_entry(3, 'h00F);
    last = AW'(3); period = DIV_W'(2); mode = 2'b00;
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      check("loop_led", 32'(led), exp_tp1[i]);
    end
    check("loop_busy", 32'(busy), 1);

    // One-shot completes and holds the final pattern
    mode = 2'b01; start = 1'b1;
    repeat (15) cycle();
    check("os_done", 32'(done), 1);
    check("os_busy", 32'(busy), 0);
    check("os_led",  32'(led),  'h00F);
    check("os_step", 32'(step), 3);
    start = 1'b1;
    cycle();
    cycle();
    check("os_restart_led", 32'(led), 'h001);

    // Mode 10 step sequence
    mode = 2'b10; period = '0; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("pp_step", 32'(step), exp_pp[i]);
    end

    // Pause delays the step by the paused cycle count
    mode = 2'b00; period = DIV_W'(2); start = 1'b1;
    cycle();
    cycle();
    pause = 1'b1;
    repeat (5) cycle();
    pause = 1'b0;
    cycle();
    check("pause_step_hold", 32'(step), 0);
    cycle();
    check("pause_step_adv", 32'(step), 1);

    // Stop beats start
    start = 1'b1; stop = 1'b1;
    cycle();
    check("startstop_busy", 32'(busy), 0);
    check("startstop_led",  32'(led),  0);

    // last clamped to DEPTH-1; out-of-range write dropped
    write_entry(20, 'h3FF);
    write_entry(17, 'h2AA);
    last = AW'(31); period = '0; mode = 2'b00; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 17) check("clamp_step17", 32'(step), 17);
      if (i == 18) check("clamp_wrap",   32'(step), 0);
    end

    // last=0 one-shot finishes after one dwell
    last = '0; mode = 2'b01; period = DIV_W'(4); start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 4) check("last0_not_done", 32'(done), 0);
      if (i == 5) check("last0_done",     32'(done), 1);
    end

    // Reset mid-run clears the table
    last = AW'(3); mode = 2'b00; period = DIV_W'(1); start = 1'b1;
    repeat (5) cycle();
    apply_reset();
    start = 1'b1;
    cycle();
    cycle();
    check("post_rst_led",  32'(led),  0);
    check("post_rst_busy", 32'(busy), 1);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 4)) write_entry(int'($urandom_range(0, 31)), $urandom);
      mode   = 2'($urandom_range(0, 3));
      last   = (r % 2 == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom_range(0, 31));
      period = DIV_W'($urandom_range(0, 3));
      start  = 1'b1;
      cycle();
      repeat ($urandom_range(10, 60)) begin
        pause = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 49) == 0) start = 1'b1;
        if ($urandom_range(0, 79) == 0) stop = 1'b1;
        if ($urandom_range(0, 29) == 0) period = DIV_W'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
          wr_en   = 1'b1;
          wr_addr = AW'($urandom_range(0, 31));
          wr_data = WIDTH'($urandom);
        end
        cycle();
      end
      pause = 1'b0;
      if (r == 20) apply_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
